// File: rtl/moving_avg_filter_if.sv
// Sample/control/result bundle between the ADC capture side and the moving-average filter.
// The master drives samples and control; the slave (the filter) drives the averaged result.
interface moving_avg_filter_if #(
    parameter int DW       = 14,
    parameter int NCH      = 2,
    parameter int LOG2_MAX = 4
);
    localparam int WSW = $clog2(LOG2_MAX + 1);

    logic                clr;
    logic [WSW-1:0]      win_sel;
    logic                in_valid;
    logic [NCH*DW-1:0]   in_data;
    logic                out_valid;
    logic [NCH*DW-1:0]   out_data;
    logic                primed;

    modport master (
        output clr, win_sel, in_valid, in_data,
        input  out_valid, out_data, primed
    );

    modport slave (
        input  clr, win_sel, in_valid, in_data,
        output out_valid, out_data, primed
    );
endinterface

// File: rtl/moving_avg_filter.sv
// Multi-channel boxcar moving average with a per-channel circular delay line, run-time
// power-of-two window, rounded/saturated output and a primed flag. Two-stage pipeline.
module moving_avg_filter #(
    parameter int DW       = 14,
    parameter int NCH      = 2,
    parameter int LOG2_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    moving_avg_filter_if.slave    bus
);
    localparam int WSW   = $clog2(LOG2_MAX + 1);
    localparam int AW    = DW + LOG2_MAX;
    localparam int AW1   = AW + 1;
    localparam int FW    = LOG2_MAX + 1;
    localparam int DEPTH = 1 << LOG2_MAX;
    localparam logic signed [AW:0] SAT_MAX = AW1'((1 << (DW - 1)) - 1);
    localparam logic signed [AW:0] SAT_MIN = -AW1'(1 << (DW - 1));

    logic [WSW-1:0]        win_clamp;
    logic [WSW-1:0]        win_reg;
    logic                  win_chg;
    logic                  flush;
    logic                  accept;
    logic [FW-1:0]         n_cur;
    logic [FW-1:0]         fill;
    logic [LOG2_MAX-1:0]   wp;
    logic [LOG2_MAX-1:0]   rd_idx;
    logic                  s1_valid;

    logic signed [DW-1:0]  mem      [NCH][DEPTH];
    logic signed [DW-1:0]  new_s    [NCH];
    logic signed [DW-1:0]  old_s    [NCH];
    logic signed [AW-1:0]  acc      [NCH];
    logic signed [AW-1:0]  acc_next [NCH];
    logic signed [AW:0]    rnd;
    logic signed [AW:0]    sum_r    [NCH];
    logic signed [AW:0]    shr      [NCH];
    logic signed [DW-1:0]  avg      [NCH];

    assign win_clamp = (bus.win_sel > WSW'(LOG2_MAX)) ? WSW'(LOG2_MAX) : bus.win_sel;
    assign win_chg   = (win_clamp != win_reg);
    assign flush     = bus.clr | win_chg;
    assign accept    = bus.in_valid & ~flush;
    assign n_cur     = FW'(1) << win_reg;
    // For the maximum window the truncated N is 0, so the oldest entry is the one about to be overwritten.
    assign rd_idx    = wp - n_cur[LOG2_MAX-1:0];

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            new_s[c]    = bus.in_data[c*DW +: DW];
            old_s[c]    = (fill < n_cur) ? '0 : mem[c][rd_idx];
            acc_next[c] = acc[c] + AW'(new_s[c]) - AW'(old_s[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < NCH; c++) begin
                mem[c][wp] <= new_s[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_reg  <= '0;
            wp       <= '0;
            fill     <= '0;
            s1_valid <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                acc[c] <= '0;
            end
        end else begin
            s1_valid <= accept;
            if (flush) begin
                win_reg <= win_clamp;
                wp      <= '0;
                fill    <= '0;
                for (int c = 0; c < NCH; c++) begin
                    acc[c] <= '0;
                end
            end else if (accept) begin
                wp <= wp + LOG2_MAX'(1);
                if (fill < n_cur) begin
                    fill <= fill + FW'(1);
                end
                for (int c = 0; c < NCH; c++) begin
                    acc[c] <= acc_next[c];
                end
            end
        end
    end

    always_comb begin
        rnd = (win_reg == '0) ? '0 : (AW1'(1) << (win_reg - WSW'(1)));
        for (int c = 0; c < NCH; c++) begin
            sum_r[c] = AW1'(acc[c]) + rnd;
            shr[c]   = sum_r[c] >>> win_reg;
            if (shr[c] > SAT_MAX) begin
                avg[c] = SAT_MAX[DW-1:0];
            end else if (shr[c] < SAT_MIN) begin
                avg[c] = SAT_MIN[DW-1:0];
            end else begin
                avg[c] = shr[c][DW-1:0];
            end
        end
    end

    // fill here already reflects the sample in stage 2, so fill == N marks the N-th output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.primed    <= 1'b0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.primed    <= 1'b0;
        end else begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                for (int c = 0; c < NCH; c++) begin
                    bus.out_data[c*DW +: DW] <= avg[c];
                end
                bus.primed <= (fill == n_cur);
            end
        end
    end
endmodule

// File: tb/tb_moving_avg_filter.sv
// Scoreboard bench for moving_avg_filter: a reference model pushes expected results when a
// sample is driven; a negedge monitor pops and compares them on every out_valid pulse.
module tb_moving_avg_filter;
    typedef struct {
        logic [27:0] data;
        logic        primed;
    } exp_t;

    logic clk;
    logic rst;
    moving_avg_filter_if #(.DW(14), .NCH(2), .LOG2_MAX(4)) bus ();

    moving_avg_filter #(.DW(14), .NCH(2), .LOG2_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    pass_cnt = 0;
    int    total_cnt = 0;
    exp_t  q[$];
    exp_t  mon_e;
    exp_t  drv_e;
    int    h0[$];
    int    h1[$];
    int    cur_k = 0;
    bit    prev_acc = 0;
    bit    hold_chk = 0;
    logic [27:0] last_exp = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [13:0] avg_of(input int h[$], input int n);
        int s, r, num;
        s = 0;
        for (int i = 0; i < n && i < h.size(); i++) s += h[h.size() - 1 - i];
        if (n == 1) r = s;
        else begin
            num = s + n / 2;
            r = num / n;
            if ((num % n) != 0 && num < 0) r--;
        end
        if (r > 8191) r = 8191;
        if (r < -8192) r = -8192;
        return 14'(r);
    endfunction

    task automatic cyc(input bit v, input int d0, input int d1, input bit c, input int ws);
        int kc, n;
        bit fl;
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.clr      = c;
        bus.win_sel  = 3'(ws);
        bus.in_data  = {14'(d1), 14'(d0)};
        kc = (ws > 4) ? 4 : ws;
        fl = c || (kc != cur_k);
        if (fl) begin
            if (prev_acc) void'(q.pop_back());
            h0.delete();
            h1.delete();
            cur_k    = kc;
            prev_acc = 0;
        end else if (v) begin
            h0.push_back(d0);
            h1.push_back(d1);
            if (h0.size() > 16) begin
                void'(h0.pop_front());
                void'(h1.pop_front());
            end
            n = 1 << cur_k;
            drv_e.data   = {avg_of(h1, n), avg_of(h0, n)};
            drv_e.primed = (h0.size() >= n);
            q.push_back(drv_e);
            prev_acc = 1;
        end else begin
            prev_acc = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                mon_e = q.pop_front();
                chk("out_data", 32'(bus.out_data), 32'(mon_e.data));
                chk("primed", 32'(bus.primed), 32'(mon_e.primed));
                last_exp = mon_e.data;
            end
        end else if (!rst && hold_chk) begin
            chk("hold_data", 32'(bus.out_data), 32'(last_exp));
        end
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.clr      = 1'b0;
        bus.win_sel  = '0;
        bus.in_data  = '0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_primed", 32'(bus.primed), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // stream, then asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) cyc(1, 500 + i, -500, 0, 4);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_out_data", 32'(bus.out_data), 32'd0);
        chk("async_rst_primed", 32'(bus.primed), 32'd0);
        q.delete();
        h0.delete();
        h1.delete();
        cur_k = 0;
        prev_acc = 0;
        bus.in_valid = 1'b0;
        bus.win_sel  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // passthrough
        cyc(1, 100, 7, 0, 0);
        cyc(1, -3, 8191, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // step warm-up, N=16
        for (int i = 0; i < 20; i++) cyc(1, 1000, -1000, 0, 4);

        // extremes, N=2
        for (int i = 0; i < 10; i++) cyc(1, (i % 2) ? -8192 : 8191, -8192, 0, 1);
        for (int i = 0; i < 6; i++) cyc(1, 8191, -8192, 0, 1);

        // ramp through the delay-line wrap, N=16
        for (int i = 0; i < 40; i++) cyc(1, i, -i, 0, 4);

        // window change 4 -> 2 with a sample presented in the same cycle
        cyc(1, 50, -50, 0, 2);
        for (int i = 0; i < 6; i++) cyc(1, 10 * (i + 1), -7 * i, 0, 2);

        // out-of-range win_sel clamps to 4
        cyc(1, 123, 456, 0, 7);
        for (int i = 0; i < 18; i++) cyc(1, 300 - 37 * i, 29 * i - 200, 0, 7);

        // clr together with in_valid, right after an accepted sample
        cyc(1, 999, -999, 1, 7);
        for (int i = 0; i < 5; i++) cyc(1, 64 * i, -64 * i, 0, 7);

        // 1/3 duty input with hold checks between pulses
        for (int i = 0; i < 12; i++) begin
            cyc(1, int'($urandom_range(16383)) - 8192, int'($urandom_range(16383)) - 8192, 0, 7);
            cyc(0, 0, 0, 0, 7);
            cyc(0, 0, 0, 0, 7);
            if (i == 2) hold_chk = 1;
        end
        hold_chk = 0;

        for (int i = 0; i < 10 && q.size() != 0; i++) cyc(0, 0, 0, 0, 7);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
